// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared types and constants for the demux dispatcher
package dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int RR_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/demux_onehot_dec.sv
// rtl/demux_onehot_dec.sv - 2-bit destination plus valid to one-hot channel valid
module demux_onehot_dec
    import dispatch_pkg::*;
(
    input  logic              valid,
    input  logic [RR_W-1:0]   dest,
    output logic [NUM_CH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (valid) begin
            onehot[dest] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_dispatcher.sv
// rtl/demux_dispatcher.sv - one-entry 1-to-4 dispatcher, addressed or round-robin routing
// Optional stall timeout with drop pulse enabled by DISPATCH_TIMEOUT_EN.
module demux_dispatcher
    import dispatch_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              drop,
    output logic [15:0]       sent_cnt
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("demux_dispatcher: TIMEOUT must be within 2..255");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RR_W-1:0]   dest_q, dest_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic              rr_item_q, rr_item_d;
    logic [15:0]       sent_q, sent_d;
    logic              complete;
    logic              capture;

`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0]        stall_q, stall_d;
    logic              drop_q, drop_d;
    logic              stalled;
`endif

    assign in_ready = rst_n && en &&
                      ((state_q == ST_IDLE) || ((state_q == ST_SEND) && out_ready[dest_q]));
    assign complete = (state_q == ST_SEND) && out_ready[dest_q];
    assign capture  = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dest_d    = dest_q;
        rr_d      = rr_q;
        rr_item_d = rr_item_q;
        sent_d    = sent_q;
`ifdef DISPATCH_TIMEOUT_EN
        stall_d   = stall_q;
        drop_d    = 1'b0;
        stalled   = (state_q == ST_SEND) && !out_ready[dest_q];
`endif

        if (complete) begin
            sent_d  = sent_q + 16'd1;
            state_d = ST_IDLE;
            if (rr_item_q) begin
                rr_d = dest_q + 2'd1;
            end
        end

`ifdef DISPATCH_TIMEOUT_EN
        if (complete) begin
            stall_d = '0;
        end else if (stalled) begin
            if (stall_q == 8'(TIMEOUT - 1)) begin
                stall_d = '0;
                drop_d  = 1'b1;
                state_d = ST_IDLE;
                if (rr_item_q) begin
                    rr_d = dest_q + 2'd1;
                end
            end else begin
                stall_d = stall_q + 8'd1;
            end
        end
`endif

        // A same-cycle capture must see the pointer already advanced past the departing item.
        if (capture) begin
            data_d    = in_data;
            dest_d    = mode ? rr_d : in_dest;
            rr_item_d = mode;
            state_d   = ST_SEND;
`ifdef DISPATCH_TIMEOUT_EN
            stall_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            dest_q    <= '0;
            rr_q      <= '0;
            rr_item_q <= 1'b0;
            sent_q    <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            stall_q   <= '0;
            drop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            dest_q    <= dest_d;
            rr_q      <= rr_d;
            rr_item_q <= rr_item_d;
            sent_q    <= sent_d;
`ifdef DISPATCH_TIMEOUT_EN
            stall_q   <= stall_d;
            drop_q    <= drop_d;
`endif
        end
    end

    demux_onehot_dec u_dec (
        .valid  (state_q == ST_SEND),
        .dest   (dest_q),
        .onehot (out_valid)
    );

    assign out_data = data_q;
    assign busy     = (state_q == ST_SEND);
    assign sent_cnt = sent_q;

`ifdef DISPATCH_TIMEOUT_EN
    assign drop = drop_q;
`else
    assign drop = 1'b0;
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb/tb_demux_dispatcher.sv - self-checking bench for demux_dispatcher
module tb_demux_dispatcher;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [1:0]        in_dest = '0;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = '0;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              drop;
    logic [15:0]       sent_cnt;

    always #5 clk = ~clk;

    demux_dispatcher #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .drop      (drop),
        .sent_cnt  (sent_cnt)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: a one-deep holding slot plus a routing pointer.
    logic        m_held  = 1'b0;
    logic [7:0]  m_data  = '0;
    int          m_dest  = 0;
    logic        m_rrsrc = 1'b0;
    int          m_rr    = 0;
    int          m_cnt   = 0;
    logic        m_drop  = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    int          m_stall = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_cu();
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic       done;
        logic       cap;
        exp_rdy = rst_n && en && (!m_held || out_ready[m_dest]);
        exp_ov  = m_held ? 4'(1 << m_dest) : 4'b0000;
        chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("m_out_valid", 32'(out_valid), 32'(exp_ov));
        chk("m_busy", 32'(busy), 32'(m_held));
        chk("m_drop", 32'(drop), 32'(m_drop));
        chk("m_sent_cnt", 32'(sent_cnt), 32'(m_cnt));
        if (m_held) chk("m_out_data", 32'(out_data), 32'(m_data));
        if (!rst_n) begin
            m_held = 0; m_data = 0; m_dest = 0; m_rrsrc = 0; m_rr = 0; m_cnt = 0; m_drop = 0;
`ifdef DISPATCH_TIMEOUT_EN
            m_stall = 0;
`endif
        end else begin
            done   = m_held && out_ready[m_dest];
            cap    = in_valid && exp_rdy;
            m_drop = 0;
            if (done) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (m_rrsrc) m_rr = (m_dest + 1) % 4;
                m_held = 0;
`ifdef DISPATCH_TIMEOUT_EN
                m_stall = 0;
`endif
            end
`ifdef DISPATCH_TIMEOUT_EN
            else if (m_held) begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    m_drop = 1; m_held = 0; m_stall = 0;
                    if (m_rrsrc) m_rr = (m_dest + 1) % 4;
                end
            end
`endif
            if (cap) begin
                m_held  = 1;
                m_data  = in_data;
                m_dest  = mode ? m_rr : int'(in_dest);
                m_rrsrc = mode;
`ifdef DISPATCH_TIMEOUT_EN
                m_stall = 0;
`endif
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cu();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       en;
        logic       mode;
        logic       vld;
        logic [7:0] data;
        logic [1:0] dest;
        logic [3:0] ordy;
        logic [3:0] ov;
        logic [7:0] od;
        logic       rdy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // addressed transfer
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hA5, 2'd2, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 4'b0100, 8'hA5, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd1};
        // round-robin back-to-back
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h10, 2'd3, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h11, 2'd3, 4'hF, 4'b0001, 8'h10, 1'b1, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h12, 2'd3, 4'hF, 4'b0010, 8'h11, 1'b1, 16'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h13, 2'd3, 4'hF, 4'b0100, 8'h12, 1'b1, 16'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h14, 2'd3, 4'hF, 4'b1000, 8'h13, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd3, 4'hF, 4'b0001, 8'h14, 1'b1, 16'd5};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd6};
        // backpressure on channel 1 with other channels ready
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h5C, 2'd1, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd6};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h77, 2'd3, 4'hD, 4'b0010, 8'h5C, 1'b0, 16'd6};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h77, 2'd3, 4'hD, 4'b0010, 8'h5C, 1'b0, 16'd6};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h77, 2'd0, 4'hD, 4'b0010, 8'h5C, 1'b0, 16'd6};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 4'b0010, 8'h5C, 1'b1, 16'd6};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd7};
        // enable low blocks capture but not completion
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h33, 2'd0, 4'hF, 4'b0000, 8'h00, 1'b0, 16'd7};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h33, 2'd0, 4'h0, 4'b0000, 8'h00, 1'b1, 16'd7};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 4'h0, 4'b0001, 8'h33, 1'b0, 16'd7};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h44, 2'd2, 4'h1, 4'b0001, 8'h33, 1'b0, 16'd7};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF, 4'b0000, 8'h00, 1'b1, 16'd8};

        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        model_cu();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; in_valid = vecs[i].vld;
            in_data = vecs[i].data; in_dest = vecs[i].dest; out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d_sent_cnt", i), 32'(sent_cnt), 32'(vecs[i].cnt));
            if (vecs[i].ov != 4'b0000)
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
            model_cu();
            @(posedge clk); #1;
        end

        // reset while an item is held on channel 2
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; in_dest = 2'd2; in_data = 8'h3C; out_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_out_valid", 32'(out_valid), 32'b0100);
        model_cu();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        model_cu();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_post_out_valid", 32'(out_valid), 32'd0);
        chk("mid_post_sent_cnt", 32'(sent_cnt), 32'd0);
        chk("mid_post_drop", 32'(drop), 32'd0);
        chk("mid_post_busy", 32'(busy), 32'd0);
        model_cu();
        @(posedge clk); #1;
        mode = 1'b1; in_valid = 1'b1; in_dest = 2'd3;
        tick();
        in_valid = 1'b0; out_ready = 4'hF;
        @(negedge clk);
        chk("mid_post_rr_ptr", 32'(out_valid), 32'b0001);
        model_cu();
        @(posedge clk); #1;

`ifdef DISPATCH_TIMEOUT_EN
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        mode = 1'b1; in_valid = 1'b1; out_ready = 4'hF;
        repeat (4) tick();
        in_valid = 1'b0; out_ready = 4'h0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk("to_stall_out_valid", 32'(out_valid), 32'b1000);
            chk("to_stall_drop", 32'(drop), 32'd0);
            model_cu();
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_drop", 32'(drop), 32'd1);
        chk("to_out_valid", 32'(out_valid), 32'd0);
        chk("to_sent_cnt", 32'(sent_cnt), 32'd3);
        model_cu();
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_drop_pulse", 32'(drop), 32'd0);
        model_cu();
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 4'hF;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("to_rr_advanced", 32'(out_valid), 32'b0001);
        model_cu();
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            en        = ($urandom_range(0, 7) != 0);
            mode      = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            in_dest   = 2'($urandom);
            out_ready = 4'($urandom);
            tick();
        end

        // counter wrap: 65535 streamed transfers, then one more
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        en = 1'b1; mode = 1'b0; in_dest = 2'd0; in_data = 8'h5A; out_ready = 4'hF; in_valid = 1'b1;
        repeat (65535) tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("wrap_ffff", 32'(sent_cnt), 32'h0000FFFF);
        model_cu();
        @(posedge clk); #1;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        @(negedge clk);
        chk("wrap_zero", 32'(sent_cnt), 32'd0);
        model_cu();
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
